// File: rtl/axi4_rd_burst_to_stream.sv
// axi4_rd_burst_to_stream
//   Frame-buffer read-side fetcher. Reads a byte-sized packet from memory over
//   the AXI4 read channel and emits it as a single AXI4-Stream packet. Bursts
//   are capped at MAX_BURST_LEN beats, split at 4 KB boundaries, and up to
//   MAX_OUTSTANDING bursts may be in flight at once. All bursts use one ID, so
//   data returns in address order.
//
// Optional feature: define FB_RD_RRESP_CHECK_EN to capture non-OKAY RRESP
//   into the sticky err_o flag. The flag clears on the next accepted start.
//   Without the macro, err_o is tied low and rresp is ignored.
//
// Ports
//   clk_i, rst_i      clock, synchronous active-high reset
//   pkt_size_i        packet size in bytes, sampled with rd_stb_i
//   addr_i            start byte address (low bits forced to word alignment)
//   rd_stb_i          start request, honoured only while idle
//   busy_o            packet in progress
//   err_o             sticky read-error flag
//   pkt_o_*           AXI4-Stream master (tdata/tkeep/tstrb/tlast/tvalid/tready/tuser/tdest)
//   mem_o_ar*/r*      AXI4 read address / read data channels
//   mem_o_aw*/w*/b*   AXI4 write channels, tied off

module axi4_rd_burst_to_stream #(
    parameter int DATA_WIDTH         = 64,
    parameter int ADDR_WIDTH         = 32,
    parameter int ID_WIDTH           = 1,
    parameter int AWUSER_WIDTH       = 1,
    parameter int WUSER_WIDTH        = 1,
    parameter int ARUSER_WIDTH       = 1,
    parameter int TUSER_WIDTH        = 1,
    parameter int TDEST_WIDTH        = 1,
    parameter int MAX_PKT_SIZE_B     = 2048,
    parameter int MAX_PKT_SIZE_WIDTH = $clog2(MAX_PKT_SIZE_B) + 1,
    parameter int MAX_BURST_LEN      = 256,
    parameter int MAX_OUTSTANDING    = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [MAX_PKT_SIZE_WIDTH-1:0] pkt_size_i,
    input  logic [ADDR_WIDTH-1:0]         addr_i,
    input  logic                          rd_stb_i,
    output logic                          busy_o,
    output logic                          err_o,
    // stream master
    output logic [DATA_WIDTH-1:0]         pkt_o_tdata,
    output logic [DATA_WIDTH/8-1:0]       pkt_o_tkeep,
    output logic [DATA_WIDTH/8-1:0]       pkt_o_tstrb,
    output logic                          pkt_o_tlast,
    output logic                          pkt_o_tvalid,
    input  logic                          pkt_o_tready,
    output logic [TUSER_WIDTH-1:0]        pkt_o_tuser,
    output logic [TDEST_WIDTH-1:0]        pkt_o_tdest,
    // read address channel
    output logic                          mem_o_arvalid,
    input  logic                          mem_o_arready,
    output logic [ID_WIDTH-1:0]           mem_o_arid,
    output logic [ADDR_WIDTH-1:0]         mem_o_araddr,
    output logic [7:0]                    mem_o_arlen,
    output logic [2:0]                    mem_o_arsize,
    output logic [1:0]                    mem_o_arburst,
    output logic                          mem_o_arlock,
    output logic [3:0]                    mem_o_arcache,
    output logic [2:0]                    mem_o_arprot,
    output logic [3:0]                    mem_o_arqos,
    output logic [3:0]                    mem_o_arregion,
    output logic [ARUSER_WIDTH-1:0]       mem_o_aruser,
    // read data channel
    input  logic                          mem_o_rvalid,
    output logic                          mem_o_rready,
    input  logic [ID_WIDTH-1:0]           mem_o_rid,
    input  logic [DATA_WIDTH-1:0]         mem_o_rdata,
    input  logic [1:0]                    mem_o_rresp,
    input  logic                          mem_o_rlast,
    // write channels (unused)
    output logic                          mem_o_awvalid,
    input  logic                          mem_o_awready,
    output logic [ID_WIDTH-1:0]           mem_o_awid,
    output logic [ADDR_WIDTH-1:0]         mem_o_awaddr,
    output logic [7:0]                    mem_o_awlen,
    output logic [2:0]                    mem_o_awsize,
    output logic [1:0]                    mem_o_awburst,
    output logic                          mem_o_awlock,
    output logic [3:0]                    mem_o_awcache,
    output logic [2:0]                    mem_o_awprot,
    output logic [3:0]                    mem_o_awqos,
    output logic [3:0]                    mem_o_awregion,
    output logic [AWUSER_WIDTH-1:0]       mem_o_awuser,
    output logic                          mem_o_wvalid,
    input  logic                          mem_o_wready,
    output logic [DATA_WIDTH-1:0]         mem_o_wdata,
    output logic [DATA_WIDTH/8-1:0]       mem_o_wstrb,
    output logic                          mem_o_wlast,
    output logic [WUSER_WIDTH-1:0]        mem_o_wuser,
    input  logic                          mem_o_bvalid,
    output logic                          mem_o_bready,
    input  logic [ID_WIDTH-1:0]           mem_o_bid,
    input  logic [1:0]                    mem_o_bresp
);

    // state  | meaning
    // IDLE_S | waiting for a non-zero-size rd_stb_i
    // RUN_S  | issuing ARs and forwarding R beats until the final word
    localparam int B     = DATA_WIDTH / 8;
    localparam int W     = $clog2(B);
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int CNT_W = MAX_PKT_SIZE_WIDTH;

    typedef enum logic {IDLE_S, RUN_S} state_t;

    state_t                r_state, w_state_nxt;
    logic [CNT_W-1:0]      r_ar_words_left, r_r_words_left;
    logic [ADDR_WIDTH-1:0] r_ar_addr, r_araddr;
    logic [7:0]            r_arlen;
    logic                  r_arvalid;
    logic [OUT_W-1:0]      r_outstanding;
    logic [B-1:0]          r_last_keep;

    logic                  w_start, w_ar_hs, w_r_hs, w_rlast_hs, w_last_word, w_done, w_ar_go;
    logic [CNT_W-1:0]      w_words, w_ar_words_nxt;
    logic [ADDR_WIDTH-1:0] w_addr_aligned, w_ar_addr_nxt;
    logic [OUT_W-1:0]      w_out_nxt;
    logic [31:0]           w_rem, w_bound, w_n;
    logic [B-1:0]          w_keep;

    assign w_start        = (r_state == IDLE_S) && rd_stb_i && (pkt_size_i != '0);
    assign w_ar_hs        = r_arvalid && mem_o_arready;
    assign w_r_hs         = (r_state == RUN_S) && mem_o_rvalid && pkt_o_tready;
    assign w_rlast_hs     = w_r_hs && mem_o_rlast;
    assign w_last_word    = (r_r_words_left == CNT_W'(1));
    assign w_done         = w_r_hs && w_last_word;
    assign w_words        = CNT_W'((32'(pkt_size_i) + 32'(B - 1)) >> W);
    assign w_addr_aligned = addr_i & ~ADDR_WIDTH'(B - 1);
    assign w_rem          = 32'(pkt_size_i) & 32'(B - 1);

    always_comb begin
        w_keep = '1;
        if (w_rem != 32'd0) begin
            for (int i = 0; i < B; i++) begin
                w_keep[i] = (32'(i) < w_rem);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE_S;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE_S:  if (w_start) w_state_nxt = RUN_S;
            RUN_S:   if (w_done)  w_state_nxt = IDLE_S;
            default: w_state_nxt = IDLE_S;
        endcase
    end

    // Next burst pointer and in-flight count, as they will be after this edge.
    // The registered AR fields are loaded from these so a new burst is
    // presented the cycle after the previous one is accepted.
    always_comb begin
        w_ar_addr_nxt  = r_ar_addr;
        w_ar_words_nxt = r_ar_words_left;
        if (w_start) begin
            w_ar_addr_nxt  = w_addr_aligned;
            w_ar_words_nxt = w_words;
        end else if (w_ar_hs) begin
            w_ar_addr_nxt  = r_ar_addr + ADDR_WIDTH'((32'(r_arlen) + 32'd1) << W);
            w_ar_words_nxt = r_ar_words_left - CNT_W'(32'(r_arlen) + 32'd1);
        end

        w_out_nxt = r_outstanding;
        if (w_ar_hs && !w_rlast_hs) begin
            w_out_nxt = r_outstanding + OUT_W'(1);
        end else if (!w_ar_hs && w_rlast_hs) begin
            w_out_nxt = r_outstanding - OUT_W'(1);
        end

        // Beats left before the next 4 KB boundary.
        w_bound = (32'd4096 - 32'(w_ar_addr_nxt[11:0])) >> W;
        w_n     = 32'(w_ar_words_nxt);
        if (w_n > 32'(MAX_BURST_LEN)) w_n = 32'(MAX_BURST_LEN);
        if (w_n > w_bound)            w_n = w_bound;

        w_ar_go = (w_state_nxt == RUN_S) && (w_ar_words_nxt != '0) &&
                  (w_out_nxt < OUT_W'(MAX_OUTSTANDING));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ar_addr       <= '0;
            r_ar_words_left <= '0;
            r_r_words_left  <= '0;
            r_outstanding   <= '0;
            r_last_keep     <= '0;
            r_arvalid       <= 1'b0;
            r_araddr        <= '0;
            r_arlen         <= '0;
        end else begin
            r_ar_addr       <= w_ar_addr_nxt;
            r_ar_words_left <= w_ar_words_nxt;
            r_outstanding   <= w_out_nxt;
            if (w_start) begin
                r_r_words_left <= w_words;
                r_last_keep    <= w_keep;
            end else if (w_r_hs) begin
                r_r_words_left <= r_r_words_left - CNT_W'(1);
            end
            // AR fields only move when nothing is pending on the channel.
            if (!r_arvalid || w_ar_hs) begin
                r_arvalid <= w_ar_go;
                if (w_ar_go) begin
                    r_araddr <= w_ar_addr_nxt;
                    r_arlen  <= 8'(w_n - 32'd1);
                end
            end
        end
    end

`ifdef FB_RD_RRESP_CHECK_EN
    logic r_err;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_err <= 1'b0;
        end else if (w_start) begin
            r_err <= 1'b0;
        end else if (w_r_hs && (mem_o_rresp != 2'b00)) begin
            r_err <= 1'b1;
        end
    end
    assign err_o = r_err;
    logic w_unused_in;
    assign w_unused_in = ^{mem_o_rid, mem_o_awready, mem_o_wready, mem_o_bvalid,
                           mem_o_bid, mem_o_bresp};
`else
    assign err_o = 1'b0;
    logic w_unused_in;
    assign w_unused_in = ^{mem_o_rid, mem_o_rresp, mem_o_awready, mem_o_wready,
                           mem_o_bvalid, mem_o_bid, mem_o_bresp};
`endif

    assign busy_o = (r_state == RUN_S);

    // Stream side is a straight wire-through of R; only tlast/tkeep are added.
    assign pkt_o_tdata  = mem_o_rdata;
    assign pkt_o_tvalid = mem_o_rvalid;
    assign mem_o_rready = pkt_o_tready;
    assign pkt_o_tlast  = w_last_word;
    assign pkt_o_tkeep  = w_last_word ? r_last_keep : '1;
    assign pkt_o_tstrb  = pkt_o_tkeep;
    assign pkt_o_tuser  = '0;
    assign pkt_o_tdest  = '0;

    assign mem_o_arvalid  = r_arvalid;
    assign mem_o_araddr   = r_araddr;
    assign mem_o_arlen    = r_arlen;
    assign mem_o_arsize   = 3'(W);
    assign mem_o_arburst  = 2'b01;
    assign mem_o_arid     = '0;
    assign mem_o_arlock   = 1'b0;
    assign mem_o_arcache  = '0;
    assign mem_o_arprot   = '0;
    assign mem_o_arqos    = '0;
    assign mem_o_arregion = '0;
    assign mem_o_aruser   = '0;

    assign mem_o_awvalid  = 1'b0;
    assign mem_o_awid     = '0;
    assign mem_o_awaddr   = '0;
    assign mem_o_awlen    = '0;
    assign mem_o_awsize   = '0;
    assign mem_o_awburst  = '0;
    assign mem_o_awlock   = 1'b0;
    assign mem_o_awcache  = '0;
    assign mem_o_awprot   = '0;
    assign mem_o_awqos    = '0;
    assign mem_o_awregion = '0;
    assign mem_o_awuser   = '0;
    assign mem_o_wvalid   = 1'b0;
    assign mem_o_wdata    = '0;
    assign mem_o_wstrb    = '0;
    assign mem_o_wlast    = 1'b0;
    assign mem_o_wuser    = '0;
    assign mem_o_bready   = 1'b1;

endmodule
